// File: rtl/bcd_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Package : bcd_pkg
//  Brief   : Shared BCD digit type, digit limits and load clamp helper.
//  Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;
   localparam bcd_digit_t BCD_MIN = 4'd0;

   // Non-decimal nibbles (A..F) are forced to the largest legal digit.
   function automatic bcd_digit_t bcd_clamp(input logic [3:0] v);
      return (v > BCD_MAX) ? BCD_MAX : v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module  : bcd_digit
//  Brief   : One registered BCD digit with clear, clamped load and
//            increment/decrement that wrap or hold at the digit limits.
//  Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       inc,
   input  logic       dec,
   input  logic       clr,
   input  logic       ld,
   input  logic [3:0] ld_val,
   input  logic       wrap_en,
   output logic [3:0] digit,
   output logic       at_max,
   output logic       at_min
);

   bcd_digit_t digit_q;
   bcd_digit_t digit_d;

   // Next digit value: clear beats load beats inc beats dec.
   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = BCD_MIN;
      end else if (ld) begin
         digit_d = bcd_clamp(ld_val);
      end else if (inc) begin
         if (digit_q == BCD_MAX) begin
            digit_d = wrap_en ? BCD_MIN : digit_q;
         end else begin
            digit_d = digit_q + 4'd1;
         end
      end else if (dec) begin
         if (digit_q == BCD_MIN) begin
            digit_d = wrap_en ? BCD_MAX : digit_q;
         end else begin
            digit_d = digit_q - 4'd1;
         end
      end
   end

   // Digit register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         digit_q <= BCD_MIN;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit  = digit_q;
   assign at_max = (digit_q == BCD_MAX);
   assign at_min = (digit_q == BCD_MIN);

endmodule
`default_nettype wire

// File: rtl/bcd_counter_chain.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module  : bcd_counter_chain
//  Brief   : NDIGITS-digit up/down BCD counter with clear, clamped load,
//            hold, terminal-count flag and registered wrap/saturate pulse.
//  Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module bcd_counter_chain
   import bcd_pkg::*;
#(
   parameter int NDIGITS = 4,
   parameter int WRAP    = 1
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   en,
   input  logic                   stp,
   input  logic                   up_dn,
   input  logic                   clr,
   input  logic                   load,
   input  logic [4*NDIGITS-1:0]   load_val,
   output logic [4*NDIGITS-1:0]   count,
   output logic                   tc,
   output logic                   ovf
);

   logic               w_step;
   logic               w_tc;
   logic               w_wrap_en;
   logic [NDIGITS-1:0] w_at_max;
   logic [NDIGITS-1:0] w_at_min;
   logic [NDIGITS:0]   w_lo_max;
   logic [NDIGITS:0]   w_lo_min;
   logic               ovf_q;
   logic               ovf_d;

   assign w_step = en && !stp;

   // Enable chain: bit i is set when every digit below i sits at its limit.
   always_comb begin
      w_lo_max    = '0;
      w_lo_min    = '0;
      w_lo_max[0] = 1'b1;
      w_lo_min[0] = 1'b1;
      for (int k = 0; k < NDIGITS; k++) begin
         w_lo_max[k+1] = w_lo_max[k] & w_at_max[k];
         w_lo_min[k+1] = w_lo_min[k] & w_at_min[k];
      end
   end

   // A full-chain limit in the current direction marks the terminal value.
   assign w_tc = w_step && !clr && !load &&
                 (up_dn ? w_lo_max[NDIGITS] : w_lo_min[NDIGITS]);

   // Ordinary digit rollovers always wrap; only a terminal step may saturate.
   assign w_wrap_en = (WRAP != 0) || !w_tc;

   genvar i;
   generate
      for (i = 0; i < NDIGITS; i++) begin : g_digit
         bcd_digit u_digit (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (w_step &&  up_dn && w_lo_max[i]),
            .dec     (w_step && !up_dn && w_lo_min[i]),
            .clr     (clr),
            .ld      (load),
            .ld_val  (load_val[4*i +: 4]),
            .wrap_en (w_wrap_en),
            .digit   (count[4*i +: 4]),
            .at_max  (w_at_max[i]),
            .at_min  (w_at_min[i])
         );
      end
   endgenerate

   // tc already excludes clr/load, so it is exactly the next-cycle pulse.
   assign ovf_d = w_tc;

   // Overflow pulse register, cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign tc  = w_tc;
   assign ovf = ovf_q;

endmodule
`default_nettype wire

// File: doc/bcd_counter_chain.md
BCD_COUNTER_CHAIN -- requirements
Module: bcd_counter_chain

Interface
REQ-001 Parameter NDIGITS, default 4, number of BCD digits (1..8).
REQ-002 Parameter WRAP, default 1; 1 = wrap at terminal value, 0 = saturate at terminal value.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  advance request, one count step per cycle while high.
REQ-006 stp  input  1  hold; while high, en is ignored and the count is frozen.
REQ-007 up_dn  input  1  direction; 1 = count up, 0 = count down.
REQ-008 clr  input  1  synchronous clear to zero.
REQ-009 load  input  1  synchronous parallel load.
REQ-010 load_val  input  4*NDIGITS  load value; digit i at bits [4i+3:4i], digit 0 least significant.
REQ-011 count  output  4*NDIGITS  registered BCD count, same digit packing as load_val.
REQ-012 tc  output  1  combinational terminal-count flag.
REQ-013 ovf  output  1  registered one-cycle wrap/saturation event pulse.

Function
REQ-014 Priority per cycle: reset_n low > clr > load > (en && !stp) step > hold.
REQ-015 clr: count becomes all zeros next edge; ovf is 0 that cycle.
REQ-016 load: each digit takes load_val digit; digits above 9 are loaded as 9; load ignores stp.
REQ-017 Step up: digit 0 increments; digit i increments only when all lower digits equal 9; a digit at 9 that increments becomes 0; all digits update on the same edge.
REQ-018 Step down: digit 0 decrements; digit i decrements only when all lower digits equal 0; a digit at 0 that decrements becomes 9.
REQ-019 Terminal value: all digits 9 when counting up; all digits 0 when counting down.
REQ-020 tc is 1 iff en && !stp && !clr && !load && count equals the terminal value for the current up_dn; otherwise 0.
REQ-021 On a step with tc=1: WRAP=1 sets count to all zeros (up) or all nines (down); WRAP=0 leaves count unchanged.
REQ-022 ovf is 1 in the cycle after any edge where tc was 1; otherwise 0. Continuous saturated stepping gives ovf high every cycle.
REQ-023 A change of up_dn takes effect on the next step, with no extra latency or lost step.
REQ-024 Step latency: count reflects a step one clock after the en cycle.
REQ-025 Count digits are never outside 0..9 under any input sequence.

Reset
REQ-026 With reset_n low at a rising edge, count = 0 and ovf = 0, regardless of other inputs.
REQ-027 Reset asserted during counting discards the pending step; the first step after release starts from 0.

Structure
REQ-028 Shared package bcd_pkg holds typedef bcd_digit_t (4-bit) and constants BCD_MAX = 9 and BCD_MIN = 0.
REQ-029 One sub-module bcd_digit holds one registered digit. Inputs: inc, dec, clr, ld, ld_val, wrap_en. Outputs: digit value, at_max, at_min.
REQ-030 The top level instantiates NDIGITS bcd_digit via generate and forms the enable chain from the at_max and at_min signals of lower digits.

Verification
REQ-031 Up ripple (NDIGITS=4, WRAP=1): load 0x0999, one en step up -> count 0x1000, tc=0, ovf=0.
REQ-032 Up wrap: count 0x9999, en up -> tc=1 that cycle; next cycle count 0x0000 and ovf=1; following cycle ovf=0.
REQ-033 Down wrap/borrow: count 0x1000, en down -> 0x0999; count 0x0000, en down -> 0x9999 and ovf=1.
REQ-034 Saturate (WRAP=0): count 0x9999, en up for 3 cycles -> count stays 0x9999, ovf high on each of the 3 following cycles.
REQ-035 Priority and hold: stp=1, en=1 for 5 cycles from 0x0042 -> count 0x0042. Then clr=1, load=1, load_val=0x00AB -> count 0x0000. Then load alone with 0x00AB -> count 0x0099.
REQ-036 Reset mid-count: at 0x0123 with en=1, reset_n=0 for one edge -> count 0x0000 and ovf=0. Next en step up -> count 0x0001.
